// File: rtl/bin_to_bcd_display_if.sv
// Handshake and display bus between a binary-value producer and the BCD converter.
// The producer uses master; the converter uses slave.
interface bin_to_bcd_display_if #(
    parameter int IN_WIDTH = 20,
    parameter int DIGITS   = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_WIDTH-1:0]   in_data;
    logic [4*DIGITS-1:0]   digits;
    logic [DIGITS-1:0]     digit_blank;
    logic                  overflow;
    logic                  done;

    modport master (
        output in_valid, in_data,
        input  in_ready, digits, digit_blank, overflow, done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, digits, digit_blank, overflow, done
    );
endinterface

// File: rtl/bin_to_bcd_display.sv
// Iterative double-dabble binary-to-BCD converter feeding per-digit 7-segment decoders.
// Publishes digits, a leading-zero blank mask and an overflow flag once per conversion.
module bin_to_bcd_display #(
    parameter int IN_WIDTH = 20,
    parameter int DIGITS   = 6
) (
    input  logic clk,
    input  logic rst,
    bin_to_bcd_display_if.slave bus
);
    // Enough BCD nibbles to hold 2^IN_WIDTH-1 (log10(2) ~= 0.30103), never fewer than DIGITS.
    localparam int BCD_DIGITS_MIN = (IN_WIDTH * 30103) / 100000 + 1;
    localparam int BCD_DIGITS     = (BCD_DIGITS_MIN > DIGITS) ? BCD_DIGITS_MIN : DIGITS;
    localparam int BCD_W          = 4 * BCD_DIGITS;
    localparam int CMP_W          = ((IN_WIDTH > 4 * DIGITS) ? IN_WIDTH : 4 * DIGITS) + 1;
    localparam int CNT_W          = $clog2(IN_WIDTH + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    function automatic logic [CMP_W-1:0] max_value();
        logic [CMP_W-1:0] p;
        p = CMP_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
            p = p * CMP_W'(10);
        end
        return p - CMP_W'(1);
    endfunction

    localparam logic [CMP_W-1:0] MAX_VALUE = max_value();

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t                    state_reg;
    logic [IN_WIDTH-1:0]       shift_reg;
    logic [BCD_W-1:0]          bcd_reg;
    logic [CNT_W-1:0]          count_reg;
    logic                      ovf_pending_reg;

    logic [BCD_W-1:0]          bcd_adj;
    logic [BCD_W+IN_WIDTH-1:0] shifted;
    logic [DIGITS:1]           zero_above;
    logic [DIGITS-1:0]         blank_next;
    logic                      ovf_next;

    assign bus.in_ready = (state_reg == IDLE);
    assign ovf_next     = {{(CMP_W-IN_WIDTH){1'b0}}, bus.in_data} > MAX_VALUE;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
        end

        // zero_above[k]: digit k and every more-significant output digit are zero.
        assign zero_above[DIGITS] = 1'b1;
        for (gi = 1; gi < DIGITS; gi++) begin : g_zero
            assign zero_above[gi] = zero_above[gi+1] && (bcd_reg[4*gi +: 4] == 4'd0);
        end

        assign blank_next[0] = 1'b0;
        for (gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign blank_next[gi] = zero_above[gi];
        end
    endgenerate

    assign shifted = {bcd_adj, shift_reg} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            shift_reg        <= '0;
            bcd_reg          <= '0;
            count_reg        <= '0;
            ovf_pending_reg  <= 1'b0;
            bus.digits       <= '0;
            bus.digit_blank  <= BLANK_RST;
            bus.overflow     <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        shift_reg       <= bus.in_data;
                        bcd_reg         <= '0;
                        ovf_pending_reg <= ovf_next;
                        count_reg       <= CNT_W'(IN_WIDTH);
                        state_reg       <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_reg, shift_reg} <= shifted;
                    count_reg            <= count_reg - 1'b1;
                    if (count_reg == CNT_W'(1)) begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    if (ovf_pending_reg) begin
                        bus.digits      <= {DIGITS{4'hE}};
                        bus.digit_blank <= '0;
                        bus.overflow    <= 1'b1;
                    end else begin
                        bus.digits      <= bcd_reg[4*DIGITS-1:0];
                        bus.digit_blank <= blank_next;
                        bus.overflow    <= 1'b0;
                    end
                    bus.done  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Directed and randomized checks of bin_to_bcd_display against a decimal-arithmetic model.
module tb_bin_to_bcd_display;
    localparam int IN_WIDTH = 20;
    localparam int DIGITS   = 6;
    localparam int LAT      = IN_WIDTH + 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   xact   = 0;

    always #5 clk = ~clk;

    bin_to_bcd_display_if #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_display #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal model: digit k is (v / 10^k) % 10; digit k>0 is blank when v < 10^k.
    task automatic ref_model(input int unsigned v, output logic [23:0] d,
                             output logic [5:0] b, output logic o);
        int unsigned tmp;
        int unsigned lim;
        if (v > 999999) begin
            d = 24'hEEEEEE;
            b = 6'b0;
            o = 1'b1;
        end else begin
            o   = 1'b0;
            tmp = v;
            lim = 1;
            for (int k = 0; k < DIGITS; k++) begin
                d[4*k +: 4] = 4'(tmp % 10);
                tmp         = tmp / 10;
                b[k]        = (k > 0) && (v < lim);
                lim         = lim * 10;
            end
        end
    endtask

    task automatic check_outputs(input string tag, input int unsigned v);
        logic [23:0] d;
        logic [5:0]  b;
        logic        o;
        ref_model(v, d, b, o);
        check({tag, ".digits"}, 32'(bus.digits), 32'(d));
        check({tag, ".blank"},  32'(bus.digit_blank), 32'(b));
        check({tag, ".ovf"},    32'(bus.overflow), 32'(o));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".digits"}, 32'(bus.digits), 32'h0);
        check({tag, ".blank"},  32'(bus.digit_blank), 32'b111110);
        check({tag, ".ovf"},    32'(bus.overflow), 32'h0);
        check({tag, ".done"},   32'(bus.done), 32'h0);
        check({tag, ".ready"},  32'(bus.in_ready), 32'h1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        check("idle_wait", 32'(bus.in_ready), 32'h1);
    endtask

    task automatic convert(input int unsigned v);
        int done_at     = -1;
        bit ready_early = 1'b0;
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_data  = IN_WIDTH'(v);
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = IN_WIDTH'($urandom);
        for (int n = 1; n <= LAT + 10; n++) begin
            tick();
            if (bus.done) begin
                done_at = n;
                break;
            end
            if (bus.in_ready) ready_early = 1'b1;
        end
        check("latency", 32'(done_at), 32'(LAT));
        check("busy_ready", 32'(ready_early), 32'h0);
        check("ready_after", 32'(bus.in_ready), 32'h1);
        check_outputs("conv", v);
        xact++;
        $display("xact %0d: in=%0d digits=%h blank=%b ovf=%b done_at=%0d",
                 xact, v, bus.digits, bus.digit_blank, bus.overflow, done_at);
        tick();
        check("done_pulse", 32'(bus.done), 32'h0);
        check_outputs("hold", v);
    endtask

    initial begin
        int first;
        int second;
        int done_cnt;
        int unsigned v;

        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #2 rst = 1'b1;
        #1;
        check("ready_in_rst", 32'(bus.in_ready), 32'h1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_reset_values("reset");

        convert(123456);
        convert(42);
        convert(0);
        convert(999999);
        convert(1000000);
        convert(7);

        // Request while busy must be dropped, not queued.
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_data  = IN_WIDTH'(305);
        tick();
        bus.in_valid = 1'b0;
        done_cnt     = 0;
        for (int n = 1; n <= 60; n++) begin
            if (n == 5) begin
                bus.in_valid = 1'b1;
                bus.in_data  = IN_WIDTH'(777);
            end
            if (n == 6) bus.in_valid = 1'b0;
            tick();
            if (bus.done) done_cnt++;
        end
        check("busy_done_cnt", 32'(done_cnt), 32'h1);
        check_outputs("busy", 305);
        xact++;
        $display("xact %0d: in=305 (777 while busy) digits=%h dones=%0d", xact, bus.digits, done_cnt);

        // Back-to-back with in_valid held high.
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_data  = IN_WIDTH'(11);
        tick();
        bus.in_data  = IN_WIDTH'(22);
        first        = -1;
        second       = -1;
        for (int n = 1; n <= 80; n++) begin
            tick();
            if (bus.done) begin
                if (first < 0) begin
                    first = n;
                    check_outputs("b2b_first", 11);
                end else begin
                    second = n;
                    check_outputs("b2b_second", 22);
                    bus.in_valid = 1'b0;
                    break;
                end
            end
        end
        check("b2b_first_at", 32'(first), 32'(LAT));
        check("b2b_gap", 32'(second - first), 32'(IN_WIDTH + 2));
        done_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        check("b2b_no_extra", 32'(done_cnt), 32'h0);
        xact++;
        $display("xact %0d: b2b 11,22 done at %0d and %0d", xact, first, second);

        // Reset in the middle of a conversion.
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_data  = IN_WIDTH'(654321);
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        tick();
        rst      = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        check("mid_rst_no_done", 32'(done_cnt), 32'h0);
        check_outputs("mid_rst_hold", 0);
        xact++;
        $display("xact %0d: 654321 aborted by reset, dones=%0d", xact, done_cnt);
        convert(8);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, (1 << IN_WIDTH) - 1);
                1:       v = $urandom_range(0, 999);
                2:       v = $urandom_range(999990, 1000010);
                default: v = $urandom_range(0, 999999);
            endcase
            convert(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
